mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage of the multicycle core; consumes the execute stage's registered outputs (ctrl_mux, aluout, b, rd).
- Performs data-memory load/store over a req/ack handshake.
- Delivers write-back data, destination register and write-enable to the write-back stage.
- Drives a busy signal so the execute stage holds its outputs while a memory access is outstanding.

Parameters:
- DATA_W, 32, data/address width
- TIMEOUT, 255, max cycles to wait for i_dmem_ack before abort (1..255)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-low reset
- i_valid  input  1  execute-stage outputs valid this cycle
- i_ctrl_mux  input  3  [2]=mem->reg (load), [1]=reg->mem (store), [0]=register write enable
- i_aluout  input  DATA_W  effective address / ALU result
- i_b  input  DATA_W  store data
- i_rd  input  5  destination register
- o_busy  output  1  combinational; 1 whenever state != IDLE
- o_dmem_req  output  1  memory request, held until ack or abort
- o_dmem_we  output  1  1=write, 0=read
- o_dmem_addr  output  DATA_W  memory address
- o_dmem_wdata  output  DATA_W  store data
- i_dmem_rdata  input  DATA_W  load data, valid with ack
- i_dmem_ack  input  1  memory completion, one-cycle pulse
- o_valid  output  1  one-cycle pulse, write-back fields valid
- o_wb_en  output  1  register write enable to write-back
- o_wb_data  output  DATA_W  write-back data
- o_rd  output  5  destination register
- o_err  output  1  one-cycle pulse with o_valid on timeout/fault

Behaviour:
- Reset (rst==0 at posedge):
  - State returns to IDLE.
  - All outputs are 0 (o_dmem_addr, o_dmem_wdata, o_wb_data = 0; o_rd = 0).
  - Timeout counter cleared.
  - Reset mid-access drops o_dmem_req the next edge; a late ack arriving in IDLE is ignored.
- FSM states: IDLE, ACCESS.
- IDLE, i_valid=1, i_ctrl_mux[2:1]==00 (non-memory op):
  - Stay in IDLE.
  - Next edge: o_valid=1, o_wb_data=i_aluout, o_rd=i_rd, o_wb_en=i_ctrl_mux[0], o_err=0.
  - Latency 1 cycle; throughput 1 op/cycle; o_busy stays 0.
- IDLE, i_valid=1, memory op:
  - Capture inputs.
  - Next edge: enter ACCESS with o_dmem_req=1, o_dmem_addr=i_aluout, o_dmem_wdata=i_b, o_dmem_we=i_ctrl_mux[1].
  - If both [2] and [1] are set, the store takes priority: we=1 and the load path is unused.
- ACCESS:
  - o_dmem_req, addr, we and wdata are held stable.
  - The counter increments each cycle without ack.
  - i_valid is ignored; upstream must hold its outputs while o_busy=1.
- ACCESS, i_dmem_ack=1:
  - Next edge: o_dmem_req=0, state=IDLE, o_valid=1, o_rd=captured rd, o_wb_en=captured ctrl[0].
  - o_wb_data = i_dmem_rdata for a load; captured aluout for a store.
  - Memory-op latency = 2 + memory wait cycles (i_valid edge to o_valid).
- ACCESS, counter reaches TIMEOUT without ack:
  - Next edge: o_dmem_req=0, state=IDLE, o_valid=1, o_err=1, o_wb_en=0, o_wb_data=0.
  - Ack and timeout on the same cycle: ack wins.
- o_valid, o_err: single-cycle pulses, 0 otherwise.
- o_wb_data, o_rd, o_wb_en: hold their last value when o_valid=0.
- In IDLE, o_dmem_* outputs hold their last value except o_dmem_req=0.
- An i_dmem_ack in IDLE is ignored.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - A memory op whose i_aluout[1:0] != 00 does not enter ACCESS.
  - No request is issued.
  - Next edge: o_valid=1, o_err=1, o_wb_en=0, o_wb_data=0.
- Undefined:
  - No alignment check.
  - The address is passed unmodified to o_dmem_addr.

Test Plan:
- Reset: hold rst=0 for 3 cycles with i_valid=1 → all outputs 0, o_busy=0; release → first op accepted.
- ALU pass-through: 3 back-to-back i_valid ops, ctrl=001, aluout=0x10/0x20/0x30, rd=1/2/3 → o_valid on 3 consecutive cycles with matching data/rd, o_wb_en=1, o_busy never 1.
- Load: ctrl=101, aluout=0x100, rd=7; ack after 3 wait cycles with rdata=0xDEADBEEF → req high 4 cycles, we=0, addr=0x100; o_valid with o_wb_data=0xDEADBEEF, o_rd=7, o_wb_en=1.
- Store: ctrl=010, aluout=0x200, b=0x12345678; immediate ack → we=1, wdata=0x12345678; o_valid with o_wb_en=0, o_err=0.
- Timeout: TIMEOUT=4, load with no ack → req drops after 4 cycles; o_valid=1, o_err=1, o_wb_en=0; a late ack is ignored.
- Reset mid-access: load in ACCESS, rst=0 for 1 cycle → req=0, no o_valid; a subsequent ack produces no output.

Source files
------------

// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if
// Data-memory request/acknowledge bus between the memory-access stage and
// the data memory.
//   o_dmem_req    request, held until ack or abort
//   o_dmem_we     1=write, 0=read
//   o_dmem_addr   memory address
//   o_dmem_wdata  store data
//   i_dmem_rdata  load data, valid with ack
//   i_dmem_ack    completion, one-cycle pulse
// Signal prefixes are from the stage's point of view.
// master = memory-access stage, slave = data memory.
// ---------------------------------------------------------------------------
interface mem_stage_if #(
   parameter int DATA_W = 32
);
   logic              o_dmem_req;
   logic              o_dmem_we;
   logic [DATA_W-1:0] o_dmem_addr;
   logic [DATA_W-1:0] o_dmem_wdata;
   logic [DATA_W-1:0] i_dmem_rdata;
   logic              i_dmem_ack;

   modport master (
      output o_dmem_req,
      output o_dmem_we,
      output o_dmem_addr,
      output o_dmem_wdata,
      input  i_dmem_rdata,
      input  i_dmem_ack
   );

   modport slave (
      input  o_dmem_req,
      input  o_dmem_we,
      input  o_dmem_addr,
      input  o_dmem_wdata,
      output i_dmem_rdata,
      output i_dmem_ack
   );
endinterface

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Memory-access stage of the multicycle core. Non-memory ops pass straight
// to write-back in one cycle; loads/stores run a req/ack transaction on the
// data-memory bus with a timeout abort, and o_busy holds the execute stage
// while a transaction is outstanding.
//
// Ports
//   clk, rst        clock, synchronous active-low reset
//   i_valid         execute-stage outputs valid
//   i_ctrl_mux      [2]=load, [1]=store, [0]=register write enable
//   i_aluout, i_b   address/ALU result, store data
//   i_rd            destination register
//   o_busy          1 while a memory access is outstanding (combinational)
//   dmem            data-memory bus (mem_stage_if.master)
//   o_valid         one-cycle pulse, write-back fields valid
//   o_wb_en/o_wb_data/o_rd   write-back fields, held between pulses
//   o_err           one-cycle pulse with o_valid on timeout/fault
//
// Optional feature: define MEM_ALIGN_CHECK_EN to reject memory ops whose
// address is not word aligned (error response, no bus request).
//
// State table
//   state    | meaning
//   IDLE     | no access outstanding; accepts one op per cycle
//   ACCESS   | request on the bus, waiting for ack or timeout
// ---------------------------------------------------------------------------
module mem_stage #(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   input  logic [2:0]        i_ctrl_mux,
   input  logic [DATA_W-1:0] i_aluout,
   input  logic [DATA_W-1:0] i_b,
   input  logic [4:0]        i_rd,
   output logic              o_busy,
   mem_stage_if.master       dmem,
   output logic              o_valid,
   output logic              o_wb_en,
   output logic [DATA_W-1:0] o_wb_data,
   output logic [4:0]        o_rd,
   output logic              o_err
);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_ACCESS = 1'b1;

   localparam logic [7:0] L_TIMEOUT = 8'(TIMEOUT);

   logic [0:0]        r_state;
   logic [7:0]        r_cnt;
   logic              r_dmem_req;
   logic              r_dmem_we;
   logic [DATA_W-1:0] r_dmem_addr;
   logic [DATA_W-1:0] r_dmem_wdata;
   logic              r_is_load;
   logic              r_cap_wen;
   logic [4:0]        r_cap_rd;
   logic              r_valid;
   logic              r_err;
   logic              r_wb_en;
   logic [DATA_W-1:0] r_wb_data;
   logic [4:0]        r_rd;

   logic              w_mem_op;
   logic              w_misaligned;
   logic [7:0]        w_cnt_nxt;

   assign w_mem_op  = i_ctrl_mux[2] | i_ctrl_mux[1];
   assign w_cnt_nxt = r_cnt + 8'd1;

`ifdef MEM_ALIGN_CHECK_EN
   assign w_misaligned = (i_aluout[1:0] != 2'b00);
`else
   assign w_misaligned = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= 8'd0;
         r_dmem_req   <= 1'b0;
         r_dmem_we    <= 1'b0;
         r_dmem_addr  <= '0;
         r_dmem_wdata <= '0;
         r_is_load    <= 1'b0;
         r_cap_wen    <= 1'b0;
         r_cap_rd     <= 5'd0;
         r_valid      <= 1'b0;
         r_err        <= 1'b0;
         r_wb_en      <= 1'b0;
         r_wb_data    <= '0;
         r_rd         <= 5'd0;
      end else begin
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_dmem_req <= 1'b0;
               r_cnt      <= 8'd0;
               if (i_valid) begin
                  if (!w_mem_op) begin
                     r_valid   <= 1'b1;
                     r_wb_en   <= i_ctrl_mux[0];
                     r_wb_data <= i_aluout;
                     r_rd      <= i_rd;
                  end else if (w_misaligned) begin
                     r_valid   <= 1'b1;
                     r_err     <= 1'b1;
                     r_wb_en   <= 1'b0;
                     r_wb_data <= '0;
                     r_rd      <= i_rd;
                  end else begin
                     // Store wins when both load and store bits are set.
                     r_state      <= S_ACCESS;
                     r_dmem_req   <= 1'b1;
                     r_dmem_we    <= i_ctrl_mux[1];
                     r_dmem_addr  <= i_aluout;
                     r_dmem_wdata <= i_b;
                     r_is_load    <= i_ctrl_mux[2] & ~i_ctrl_mux[1];
                     r_cap_wen    <= i_ctrl_mux[0];
                     r_cap_rd     <= i_rd;
                  end
               end
            end
            S_ACCESS: begin
               if (dmem.i_dmem_ack) begin
                  r_state    <= S_IDLE;
                  r_dmem_req <= 1'b0;
                  r_valid    <= 1'b1;
                  r_wb_en    <= r_cap_wen;
                  r_rd       <= r_cap_rd;
                  // The captured address register doubles as the ALU result.
                  r_wb_data  <= r_is_load ? dmem.i_dmem_rdata : r_dmem_addr;
               end else if (w_cnt_nxt == L_TIMEOUT) begin
                  r_state    <= S_IDLE;
                  r_dmem_req <= 1'b0;
                  r_valid    <= 1'b1;
                  r_err      <= 1'b1;
                  r_wb_en    <= 1'b0;
                  r_wb_data  <= '0;
                  r_rd       <= r_cap_rd;
               end else begin
                  r_cnt <= w_cnt_nxt;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_dmem_req <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy            = (r_state != S_IDLE);
   assign dmem.o_dmem_req   = r_dmem_req;
   assign dmem.o_dmem_we    = r_dmem_we;
   assign dmem.o_dmem_addr  = r_dmem_addr;
   assign dmem.o_dmem_wdata = r_dmem_wdata;
   assign o_valid           = r_valid;
   assign o_err             = r_err;
   assign o_wb_en           = r_wb_en;
   assign o_wb_data         = r_wb_data;
   assign o_rd              = r_rd;

endmodule
